// File: rtl/switches_debounce_pkg.sv
// Shared constants and channel state type for the switch debouncer and switches_logic.
package switches_pkg;

    localparam int unsigned NUM_SWITCHES            = 4;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 250000;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } chan_state_t;

endpackage : switches_pkg

// File: rtl/switches_debounce_if.sv
// One switch channel: raw level in, debounced level and edge pulses out.
interface switches_debounce_if;

    logic raw;
    logic level;
    logic press;
    logic rel;

    modport master (output raw, input level, press, rel);
    modport slave  (input raw, output level, press, rel);

endinterface : switches_debounce_if

// File: rtl/switches_debounce_channel.sv
// Single debounce channel: two-flop synchronizer, qualification counter,
// stable level register and registered press/release pulses.
module switch_debounce_channel
    import switches_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    switches_debounce_if.slave  bus
);

    localparam int unsigned     CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          r_sync1;
    logic          r_sync2;
    logic          r_stable;
    logic          r_press;
    logic          r_release;
    logic [CW-1:0] r_cnt;
    chan_state_t   w_state;

    // State is a pure function of the synchronized level versus the accepted one.
    assign w_state = (r_sync2 != r_stable) ? ST_PENDING : ST_IDLE;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_stable  <= 1'b0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= bus.raw;
            r_sync2   <= r_sync1;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            case (w_state)
                ST_PENDING: begin
                    if (r_cnt == CNT_MAX) begin
                        r_stable  <= r_sync2;
                        r_cnt     <= '0;
                        r_press   <= r_sync2;
                        r_release <= ~r_sync2;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: r_cnt <= '0;
            endcase
        end
    end

    assign bus.level = r_stable;
    assign bus.press = r_press;
    assign bus.rel   = r_release;

endmodule : switch_debounce_channel

// File: rtl/switches_debounce.sv
// Four independent switch debounce channels; wiring only.
module switches_debounce
    import switches_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_switch_1,
    input  logic i_switch_2,
    input  logic i_switch_3,
    input  logic i_switch_4,
    output logic o_switch_1,
    output logic o_switch_2,
    output logic o_switch_3,
    output logic o_switch_4,
    output logic o_press_1,
    output logic o_press_2,
    output logic o_press_3,
    output logic o_press_4,
    output logic o_release_1,
    output logic o_release_2,
    output logic o_release_3,
    output logic o_release_4
);

    switches_debounce_if w_bus [NUM_SWITCHES] ();

    assign w_bus[0].raw = i_switch_1;
    assign w_bus[1].raw = i_switch_2;
    assign w_bus[2].raw = i_switch_3;
    assign w_bus[3].raw = i_switch_4;

    assign o_switch_1  = w_bus[0].level;
    assign o_switch_2  = w_bus[1].level;
    assign o_switch_3  = w_bus[2].level;
    assign o_switch_4  = w_bus[3].level;
    assign o_press_1   = w_bus[0].press;
    assign o_press_2   = w_bus[1].press;
    assign o_press_3   = w_bus[2].press;
    assign o_press_4   = w_bus[3].press;
    assign o_release_1 = w_bus[0].rel;
    assign o_release_2 = w_bus[1].rel;
    assign o_release_3 = w_bus[2].rel;
    assign o_release_4 = w_bus[3].rel;

    for (genvar g = 0; g < NUM_SWITCHES; g++) begin : g_ch
        switch_debounce_channel #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_ch (
            .i_clk   (i_clk),
            .i_rst_n (i_rst_n),
            .bus     (w_bus[g])
        );
    end

endmodule : switches_debounce

// File: tb/tb_switches_debounce.sv
// Directed bench for switches_debounce with DEBOUNCE_CYCLES = 4 (6-edge latency).
module tb_switches_debounce;

    localparam int unsigned DC  = 4;
    localparam int unsigned LAT = 2 + DC;

    logic       clk;
    logic       rst_n;
    logic [3:0] raw;
    logic [3:0] lvl;
    logic [3:0] prs;
    logic [3:0] rls;
    int         errors;
    int         checks;

    switches_debounce_if sw_if [4] ();

    for (genvar g = 0; g < 4; g++) begin : g_tie
        assign sw_if[g].raw = raw[g];
        assign lvl[g]       = sw_if[g].level;
        assign prs[g]       = sw_if[g].press;
        assign rls[g]       = sw_if[g].rel;
    end

    switches_debounce #(.DEBOUNCE_CYCLES(DC)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_switch_1  (sw_if[0].raw),
        .i_switch_2  (sw_if[1].raw),
        .i_switch_3  (sw_if[2].raw),
        .i_switch_4  (sw_if[3].raw),
        .o_switch_1  (sw_if[0].level),
        .o_switch_2  (sw_if[1].level),
        .o_switch_3  (sw_if[2].level),
        .o_switch_4  (sw_if[3].level),
        .o_press_1   (sw_if[0].press),
        .o_press_2   (sw_if[1].press),
        .o_press_3   (sw_if[2].press),
        .o_press_4   (sw_if[3].press),
        .o_release_1 (sw_if[0].rel),
        .o_release_2 (sw_if[1].rel),
        .o_release_3 (sw_if[2].rel),
        .o_release_4 (sw_if[3].rel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Inputs change on the falling edge; outputs are sampled on the falling edge.
    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        raw   = 4'b0000;
        step(2);
        checks++;
        if ({lvl, prs, rls} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got=%b want=%b", {lvl, prs, rls}, 12'h000);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            checks++;
            if ({lvl, prs, rls} !== 12'h000) begin
                errors++;
                $display("FAIL idle_after_reset k=%0d: got=%b want=%b", k, {lvl, prs, rls}, 12'h000);
            end
        end
    endtask

    task automatic test_single_rise();
        logic [3:0] el, ep, er;
        raw[0] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            el = (k >= LAT) ? 4'b0001 : 4'b0000;
            ep = (k == LAT) ? 4'b0001 : 4'b0000;
            checks++;
            if ({lvl, prs, rls} !== {el, ep, 4'b0000}) begin
                errors++;
                $display("FAIL single_rise k=%0d: got=%b want=%b", k, {lvl, prs, rls}, {el, ep, 4'b0000});
            end
        end
        raw[0] = 1'b0;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            el = (k >= LAT) ? 4'b0000 : 4'b0001;
            er = (k == LAT) ? 4'b0001 : 4'b0000;
            checks++;
            if ({lvl, prs, rls} !== {el, 4'b0000, er}) begin
                errors++;
                $display("FAIL single_fall k=%0d: got=%b want=%b", k, {lvl, prs, rls}, {el, 4'b0000, er});
            end
        end
    endtask

    task automatic test_bounce();
        logic [3:0] el, ep;
        for (int t = 0; t < 8; t++) begin
            raw[1] = ((t / 2) % 2 == 0) ? 1'b1 : 1'b0;
            step(1);
            checks++;
            if ({lvl, prs, rls} !== 12'h000) begin
                errors++;
                $display("FAIL bounce_hold t=%0d: got=%b want=%b", t, {lvl, prs, rls}, 12'h000);
            end
        end
        raw[1] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            el = (k >= LAT) ? 4'b0010 : 4'b0000;
            ep = (k == LAT) ? 4'b0010 : 4'b0000;
            checks++;
            if ({lvl, prs, rls} !== {el, ep, 4'b0000}) begin
                errors++;
                $display("FAIL bounce_settle k=%0d: got=%b want=%b", k, {lvl, prs, rls}, {el, ep, 4'b0000});
            end
        end
    endtask

    task automatic test_glitch();
        raw[2] = 1'b1;
        step(LAT + 2);
        checks++;
        if ({lvl, prs, rls} !== {4'b0110, 8'h00}) begin
            errors++;
            $display("FAIL glitch_setup: got=%b want=%b", {lvl, prs, rls}, {4'b0110, 8'h00});
        end
        raw[2] = 1'b0;
        step(3);
        raw[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            checks++;
            if ({lvl, prs, rls} !== {4'b0110, 8'h00}) begin
                errors++;
                $display("FAIL glitch_dip k=%0d: got=%b want=%b", k, {lvl, prs, rls}, {4'b0110, 8'h00});
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [3:0] el, ep;
        raw[0] = 1'b1;
        raw[3] = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            el = (k >= LAT) ? 4'b1111 : 4'b0110;
            ep = (k == LAT) ? 4'b1001 : 4'b0000;
            checks++;
            if ({lvl, prs, rls} !== {el, ep, 4'b0000}) begin
                errors++;
                $display("FAIL simultaneous k=%0d: got=%b want=%b", k, {lvl, prs, rls}, {el, ep, 4'b0000});
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [3:0] el, ep;
        raw[1] = 1'b0;
        step(LAT + 2);
        checks++;
        if (lvl !== 4'b1101) begin
            errors++;
            $display("FAIL reset_mid_setup: got=%b want=%b", lvl, 4'b1101);
        end
        raw[1] = 1'b1;
        step(3);
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({lvl, prs, rls} !== 12'h000) begin
            errors++;
            $display("FAIL reset_async: got=%b want=%b", {lvl, prs, rls}, 12'h000);
        end
        step(2);
        rst_n = 1'b1;
        for (int k = 1; k <= LAT + 1; k++) begin
            step(1);
            el = (k >= LAT) ? 4'b1111 : 4'b0000;
            ep = (k == LAT) ? 4'b1111 : 4'b0000;
            checks++;
            if ({lvl, prs, rls} !== {el, ep, 4'b0000}) begin
                errors++;
                $display("FAIL reset_requalify k=%0d: got=%b want=%b", k, {lvl, prs, rls}, {el, ep, 4'b0000});
            end
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        raw    = 4'b0000;
        test_reset();
        test_single_rise();
        test_bounce();
        test_glitch();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_switches_debounce

// File: doc/switches_debounce.md
SWITCHES_DEBOUNCE -- requirements
Module: switches_debounce

Interface
REQ-001 The module SHALL have parameter DEBOUNCE_CYCLES, default 250000 (10 ms at 25 MHz): consecutive cycles a new level must persist before acceptance; legal range 2..2^20.
REQ-002 The module SHALL have port i_clk, input, 1 bit: single system clock, all logic on its rising edge.
REQ-003 The module SHALL have port i_rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-004 The module SHALL have ports i_switch_1..i_switch_4, each input, 1 bit: raw asynchronous bouncing switch levels, 1 = pressed.
REQ-005 The module SHALL have ports o_switch_1..o_switch_4, each output, 1 bit: debounced stable levels, which drive switches_logic i_switch_1..4 directly.
REQ-006 The module SHALL have ports o_press_1..o_press_4, each output, 1 bit: one-cycle pulse on each accepted 0->1 transition of o_switch_n.
REQ-007 The module SHALL have ports o_release_1..o_release_4, each output, 1 bit: one-cycle pulse on each accepted 1->0 transition of o_switch_n.

Function
REQ-008 Each channel SHALL be independent; no channel's state SHALL affect another.
REQ-009 Each raw input SHALL pass through a two-flop synchronizer (sync1, sync2) before any other use.
REQ-010 Each channel SHALL hold a counter cnt of width $clog2(DEBOUNCE_CYCLES) and a stable register stable driving o_switch_n.
REQ-011 Each channel SHALL behave as a two-state machine: IDLE (sync2 == stable, cnt held at 0) and PENDING (sync2 != stable, cnt incrementing).
REQ-012 In PENDING, if sync2 differs from stable and cnt == DEBOUNCE_CYCLES-1, then on that edge stable SHALL take sync2, cnt SHALL go to 0, and the channel SHALL return to IDLE.
REQ-013 In PENDING, if sync2 differs from stable and cnt < DEBOUNCE_CYCLES-1, cnt SHALL increment by 1.
REQ-014 Any cycle with sync2 == stable SHALL clear cnt to 0 (bounce restarts qualification); a partial count SHALL never carry over.
REQ-015 Latency: a clean raw level change held steady SHALL appear on o_switch_n exactly 2 + DEBOUNCE_CYCLES rising edges after the first edge that samples it.
REQ-016 cnt SHALL never exceed DEBOUNCE_CYCLES-1 and SHALL never wrap.
REQ-017 o_press_n SHALL be registered and high for exactly the one cycle following the edge on which stable goes 0->1.
REQ-018 o_release_n SHALL be registered and high for exactly the one cycle following the edge on which stable goes 1->0.
REQ-019 o_press_n and o_release_n SHALL never be high together.
REQ-020 Simultaneous qualification on several channels SHALL update all affected outputs on the same edge.
REQ-021 A raw pulse shorter than DEBOUNCE_CYCLES cycles (after synchronization) SHALL produce no change and no pulse.

Reset
REQ-022 While i_rst_n is low, sync1, sync2, stable, cnt and pulse registers SHALL be 0, so all o_switch_n, o_press_n and o_release_n are 0.
REQ-023 An assertion of i_rst_n mid-qualification SHALL discard the partial count immediately.
REQ-024 After release of reset with a switch held at 1, the channel SHALL qualify it normally, giving one o_press_n pulse after 2 + DEBOUNCE_CYCLES edges.
REQ-025 Reset deassertion SHALL be synchronized externally; the block SHALL not generate pulses from reset itself.

Structure
REQ-026 Package switches_pkg SHALL hold NUM_SWITCHES = 4 and DEFAULT_DEBOUNCE_CYCLES = 250000, shared with switches_logic.
REQ-027 One sub-module, switch_debounce_channel (synchronizer, counter, stable register, edge pulses), SHALL be instantiated four times.
REQ-028 The top level SHALL contain only the instances and port wiring.

Verification (bench uses DEBOUNCE_CYCLES = 4)
REQ-029 Scenario: reset low -> all 12 outputs 0; then release with all inputs 0 for 20 cycles -> outputs stay 0, no pulses.
REQ-030 Scenario: i_switch_1 0->1 held steady -> o_switch_1 goes 1 after exactly 6 edges; o_press_1 high for 1 cycle; channels 2-4 unchanged.
REQ-031 Scenario: i_switch_2 toggles 1,0,1,0 every 2 cycles, then holds 1 -> no output change during the toggling; o_switch_2 goes 1 exactly 6 edges after the final rise.
REQ-032 Scenario: stable-high i_switch_3 dips to 0 for 3 cycles -> o_switch_3 stays 1, no o_release_3.
REQ-033 Scenario: i_switch_1 and i_switch_4 rise on the same edge -> both o_switch outputs and both press pulses occur on the same cycle.
REQ-034 Scenario: i_rst_n asserted 3 cycles into qualification of i_switch_2 -> outputs 0 immediately; after release a full 6-edge qualification is required.
